// File: rtl/sdram_axi_arb.sv
// Round-robin arbiter that turns N_REQ one-word req/ack requesters into
// single-beat AXI3 transactions on the sdram_axi slave port.
// One transaction is in flight at a time; the winner's payload is latched at grant.
module sdram_axi_arb #(
  parameter int N_REQ  = 2,
  parameter int ADDR_W = 32,
  parameter int ID_W   = 12
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [N_REQ-1:0]          req_i,
  input  logic [N_REQ-1:0]          we_i,
  input  logic [N_REQ*ADDR_W-1:0]   addr_i,
  input  logic [N_REQ*32-1:0]       wdata_i,
  input  logic [N_REQ*4-1:0]        wstrb_i,
  output logic [N_REQ-1:0]          ack_o,
  output logic                      err_o,
  output logic [31:0]               rdata_o,
  output logic                      busy_o,
  output logic                      axi_awvalid_o,
  output logic [ADDR_W-1:0]         axi_awaddr_o,
  output logic [ID_W-1:0]           axi_awid_o,
  output logic [3:0]                axi_awlen_o,
  output logic [1:0]                axi_awburst_o,
  output logic                      axi_wvalid_o,
  output logic [31:0]               axi_wdata_o,
  output logic [3:0]                axi_wstrb_o,
  output logic                      axi_wlast_o,
  output logic                      axi_bready_o,
  output logic                      axi_arvalid_o,
  output logic [ADDR_W-1:0]         axi_araddr_o,
  output logic [ID_W-1:0]           axi_arid_o,
  output logic [3:0]                axi_arlen_o,
  output logic [1:0]                axi_arburst_o,
  output logic                      axi_rready_o,
  input  logic                      axi_awready_i,
  input  logic                      axi_wready_i,
  input  logic                      axi_arready_i,
  input  logic                      axi_bvalid_i,
  input  logic [1:0]                axi_bresp_i,
  input  logic [ID_W-1:0]           axi_bid_i,
  input  logic                      axi_rvalid_i,
  input  logic [31:0]               axi_rdata_i,
  input  logic [1:0]                axi_rresp_i,
  input  logic [ID_W-1:0]           axi_rid_i,
  input  logic                      axi_rlast_i
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [N_REQ-1:0] ACK_ONE = {{(N_REQ-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WR_REQ  = 3'd1,
    S_WR_RESP = 3'd2,
    S_RD_REQ  = 3'd3,
    S_RD_DATA = 3'd4,
    S_DONE    = 3'd5
  } state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W-1:0]   win_q, win_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [3:0]         wstrb_q, wstrb_d;
  logic               aw_pend_q, aw_pend_d;
  logic               w_pend_q, w_pend_d;
  logic               ar_pend_q, ar_pend_d;
  logic               err_q, err_d;
  logic [31:0]        rdata_q, rdata_d;
  logic [N_REQ-1:0]   ack_q, ack_d;
  logic               err_out_q, err_out_d;

  logic               gnt_found_s;
  logic [IDX_W-1:0]   gnt_idx_s;
  logic [IDX_W:0]     scan_s;
  logic               sel_we_s;
  logic [ADDR_W-1:0]  sel_addr_s;
  logic [31:0]        sel_wdata_s;
  logic [3:0]         sel_wstrb_s;
  logic               unused_s;

  // bid/rid are not checked and the low address bits never reach the bus.
  assign unused_s = ^{axi_bid_i, axi_rid_i, addr_q[1:0]};

  // Round-robin scan from ptr, then pick up the winner's payload.
  always_comb begin
    gnt_found_s = 1'b0;
    gnt_idx_s   = '0;
    scan_s      = '0;
    sel_we_s    = 1'b0;
    sel_addr_s  = '0;
    sel_wdata_s = 32'h0000_0000;
    sel_wstrb_s = 4'h0;
    for (int k = 0; k < N_REQ; k++) begin
      scan_s = {1'b0, ptr_q} + (IDX_W+1)'(k);
      if (scan_s >= (IDX_W+1)'(N_REQ)) begin
        scan_s = scan_s - (IDX_W+1)'(N_REQ);
      end else begin
        scan_s = scan_s;
      end
      if (!gnt_found_s && req_i[scan_s[IDX_W-1:0]]) begin
        gnt_found_s = 1'b1;
        gnt_idx_s   = scan_s[IDX_W-1:0];
      end else begin
        gnt_found_s = gnt_found_s;
      end
    end
    for (int j = 0; j < N_REQ; j++) begin
      if (gnt_idx_s == IDX_W'(j)) begin
        sel_we_s    = we_i[j];
        sel_addr_s  = addr_i[j*ADDR_W +: ADDR_W];
        sel_wdata_s = wdata_i[j*32 +: 32];
        sel_wstrb_s = wstrb_i[j*4 +: 4];
      end else begin
        sel_we_s = sel_we_s;
      end
    end
  end

  // Transaction FSM: next state, latched payload, handshake tracking, ack/err.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    win_d     = win_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    aw_pend_d = aw_pend_q;
    w_pend_d  = w_pend_q;
    ar_pend_d = ar_pend_q;
    err_d     = err_q;
    rdata_d   = rdata_q;
    ack_d     = '0;
    err_out_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (gnt_found_s) begin
          win_d   = gnt_idx_s;
          addr_d  = sel_addr_s;
          wdata_d = sel_wdata_s;
          wstrb_d = sel_wstrb_s;
          err_d   = 1'b0;
          if (sel_we_s) begin
            state_d   = S_WR_REQ;
            aw_pend_d = 1'b1;
            w_pend_d  = 1'b1;
          end else begin
            state_d   = S_RD_REQ;
            ar_pend_d = 1'b1;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WR_REQ: begin
        aw_pend_d = aw_pend_q & ~axi_awready_i;
        w_pend_d  = w_pend_q & ~axi_wready_i;
        if (!aw_pend_d && !w_pend_d) begin
          state_d = S_WR_RESP;
        end else begin
          state_d = S_WR_REQ;
        end
      end
      S_WR_RESP: begin
        if (axi_bvalid_i) begin
          err_d     = (axi_bresp_i != 2'b00);
          state_d   = S_DONE;
          ack_d     = ACK_ONE << win_q;
          err_out_d = (axi_bresp_i != 2'b00);
        end else begin
          state_d = S_WR_RESP;
        end
      end
      S_RD_REQ: begin
        if (axi_arready_i) begin
          ar_pend_d = 1'b0;
          state_d   = S_RD_DATA;
        end else begin
          state_d = S_RD_REQ;
        end
      end
      S_RD_DATA: begin
        if (axi_rvalid_i) begin
          rdata_d = axi_rdata_i;
          err_d   = err_q | (axi_rresp_i != 2'b00);
          if (axi_rlast_i) begin
            state_d   = S_DONE;
            ack_d     = ACK_ONE << win_q;
            err_out_d = err_q | (axi_rresp_i != 2'b00);
          end else begin
            state_d = S_RD_DATA;
          end
        end else begin
          state_d = S_RD_DATA;
        end
      end
      S_DONE: begin
        ptr_d   = (win_q == IDX_W'(N_REQ-1)) ? '0 : win_q + IDX_W'(1);
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      ptr_q     <= '0;
      win_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= 32'h0000_0000;
      wstrb_q   <= 4'h0;
      aw_pend_q <= 1'b0;
      w_pend_q  <= 1'b0;
      ar_pend_q <= 1'b0;
      err_q     <= 1'b0;
      rdata_q   <= 32'h0000_0000;
      ack_q     <= '0;
      err_out_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      win_q     <= win_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      aw_pend_q <= aw_pend_d;
      w_pend_q  <= w_pend_d;
      ar_pend_q <= ar_pend_d;
      err_q     <= err_d;
      rdata_q   <= rdata_d;
      ack_q     <= ack_d;
      err_out_q <= err_out_d;
    end
  end

  assign ack_o         = ack_q;
  assign err_o         = err_out_q;
  assign rdata_o       = rdata_q;
  assign busy_o        = (state_q != S_IDLE);
  assign axi_awvalid_o = aw_pend_q;
  assign axi_awaddr_o  = {addr_q[ADDR_W-1:2], 2'b00};
  assign axi_awid_o    = ID_W'(win_q);
  assign axi_awlen_o   = 4'd0;
  assign axi_awburst_o = 2'b01;
  assign axi_wvalid_o  = w_pend_q;
  assign axi_wdata_o   = wdata_q;
  assign axi_wstrb_o   = wstrb_q;
  assign axi_wlast_o   = 1'b1;
  assign axi_bready_o  = (state_q == S_WR_RESP);
  assign axi_arvalid_o = ar_pend_q;
  assign axi_araddr_o  = {addr_q[ADDR_W-1:2], 2'b00};
  assign axi_arid_o    = ID_W'(win_q);
  assign axi_arlen_o   = 4'd0;
  assign axi_arburst_o = 2'b01;
  assign axi_rready_o  = (state_q == S_RD_DATA);

endmodule

// File: doc/sdram_axi_arb.md
Name: sdram_axi_arb

Overview:
- Shares the single AXI3 slave port of the SDRAM controller (`sdram_axi`) between N_REQ simple requesters in programmable logic, e.g. a video fetcher and a DMA engine.
- Each requester uses a one-word req/ack interface. The block grants one requester at a time, round-robin, and converts its access into one single-beat AXI transaction (len=0, INCR).
- Only one transaction is outstanding at a time. The block sits between PL masters and the `sdram_axi` inport on the FCLK0 domain.

Parameters:
N_REQ, 2, number of requesters (2..8)
ADDR_W, 32, byte address width
ID_W, 12, AXI ID width; ID driven = granted requester index, zero-extended

Ports:
clk_i  in  1  system clock (FCLK0 domain)
rst_ni  in  1  asynchronous active-low reset
req_i  in  N_REQ  per-requester access request, level, held until ack
we_i  in  N_REQ  1=write, 0=read, per requester
addr_i  in  N_REQ*ADDR_W  byte addresses, requester i at [i*ADDR_W +: ADDR_W]
wdata_i  in  N_REQ*32  write data, packed likewise
wstrb_i  in  N_REQ*4  byte strobes, packed likewise
ack_o  out  N_REQ  one-cycle completion pulse to the granted requester
err_o  out  1  valid with ack_o; 1 = non-OKAY bresp/rresp
rdata_o  out  32  read data, valid with ack_o on reads, held until next read completes
busy_o  out  1  high whenever state != IDLE
axi_aw{valid,addr,id,len,burst}_o  out  1,ADDR_W,ID_W,4,2  write address channel
axi_w{valid,data,strb,last}_o  out  1,32,4,1  write data channel
axi_bready_o  out  1  write response ready
axi_ar{valid,addr,id,len,burst}_o  out  1,ADDR_W,ID_W,4,2  read address channel
axi_rready_o  out  1  read data ready
axi_awready_i, axi_wready_i, axi_arready_i  in  1 each  channel readies
axi_bvalid_i, axi_bresp_i, axi_bid_i  in  1,2,ID_W  write response
axi_rvalid_i, axi_rdata_i, axi_rresp_i, axi_rid_i, axi_rlast_i  in  1,32,2,ID_W,1  read data

Behaviour:
- Reset (async assert, sync deassert by user):
  - All valid, ready and ack outputs are 0; err_o=0; rdata_o=0; busy_o=0.
  - State=IDLE; round-robin pointer ptr=0.
  - Reset mid-transaction abandons it with no ack. The slave is reset together with this block.
- Constant outputs: awlen/arlen=0, awburst/arburst=2'b01, wlast=1 whenever wvalid. Address bits [1:0] are forced to 0 on the bus.
- FSM states: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, DONE.
- IDLE:
  - If any req_i is set, the winner is the first set bit scanning ptr, ptr+1, … mod N_REQ.
  - Latch winner index, we, addr, wdata and wstrb into internal registers.
  - Next state is WR_REQ if we=1, otherwise RD_REQ.
  - Bus valids rise on the cycle after the grant decision.
- WR_REQ:
  - awvalid and wvalid are asserted together. Each drops independently on its own handshake; the two handshakes may complete in the same cycle or in either order.
  - Exit to WR_RESP once both handshakes are done. Payload is stable while valid is high.
- WR_RESP: bready=1. On bvalid: err = (bresp != 0), go to DONE.
- RD_REQ: arvalid=1 until arready, then go to RD_DATA.
- RD_DATA:
  - rready=1. Each rvalid beat captures rdata into rdata_o and ORs (rresp != 0) into err.
  - Exit to DONE only on a beat with rlast=1. Extra beats are absorbed defensively.
- DONE:
  - For exactly one cycle: ack_o[winner]=1, err_o=err.
  - ptr = (winner+1) mod N_REQ. Go to IDLE.
  - A request still held on the ack cycle is not re-granted in that cycle; earliest next grant is the following IDLE cycle.
- Minimum latency, with all slave readies high and a response on the next cycle:
  - Write: grant to ack = 4 cycles (IDLE, WR_REQ, WR_RESP, DONE).
  - Read: same, 4 cycles.
- Requester rules:
  - req_i dropped after grant: the transaction still completes and ack still pulses; the requester ignores it.
  - Requester inputs other than req_i are sampled only at grant.
- bid/rid are not checked.
- Only one AXI transaction is outstanding at any time. aw/w and ar are never active simultaneously.

Test Plan:
- Reset: rst_ni low with random AXI inputs -> all valids 0, ack_o=0, busy_o=0. After release with no req: no bus activity for 100 cycles.
- Single write: req0 with addr=0x0000_1006, wdata=0xDEADBEEF, wstrb=0xF; slave readies high, bresp=0 one cycle later -> awaddr=0x0000_1004, awid=0, awlen=0, wlast=1; ack_o=01 exactly once, 4 cycles after grant; err_o=0.
- Read: req1 read addr=0x100; slave returns rdata=0x12345678, rlast=1, rresp=0 -> arid=1; rdata_o=0x12345678 on the ack_o=10 cycle; rdata_o holds afterwards.
- Fairness: req=11 held continuously for 8 transactions -> grants alternate 0,1,0,1,…; each requester gets 4 acks.
- Handshake skew, write: awready delayed 3 cycles, wready immediate, then the reverse ordering -> wvalid drops after its handshake while awvalid is held; exactly one aw and one w handshake per transaction in both orderings.
- Error: bresp=2'b10 on a write, then rresp=2'b11 on a read -> err_o=1 on both ack cycles; arbitration continues normally.
